sv_encoder_step_gen: RTL and testbench

- Upstream stage of sv_trigger_gen: converts raw quadrature encoder lines A/B into a one-cycle step pulse on o_step.
- o_step drives sv_trigger_gen encoder_step_input.
- Synchronises, glitch-filters and decodes A/B, tracks signed position, and divides qualifying counts by a programmable ratio.

---
 rtl/sv_encoder_step_gen.sv | 153 +++++++++++++++
 tb/tb_sv_encoder_step_gen.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sv_encoder_step_gen.sv
// Quadrature encoder front end: synchronises, filters and decodes A/B, tracks
// signed position and divides qualifying counts into one-cycle step pulses.
module sv_encoder_step_gen #(
    parameter int FILT_LEN = 4,
    parameter int DIV_W    = 16,
    parameter int POS_W    = 32
) (
    input  logic                    i_clk,
    input  logic                    i_aresetn,
    input  logic                    enc_a,
    input  logic                    enc_b,
    input  logic                    i_en,
    input  logic [1:0]              i_dir_mode,
    input  logic [DIV_W-1:0]        i_step_div,
    output logic                    o_step,
    output logic signed [POS_W-1:0] o_position,
    output logic                    o_dir,
    output logic                    o_err
);
    localparam int FCW = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;
    localparam int ICW = $clog2(FILT_LEN + 3);
    localparam logic [FCW-1:0] FILT_LAST = FCW'(FILT_LEN - 1);
    localparam logic [ICW-1:0] INIT_LAST = ICW'(FILT_LEN + 1);
    localparam logic signed [POS_W-1:0] POS_ONE = POS_W'(1);

    // Position of an {A,B} level along the forward cycle 00->01->11->10.
    function automatic logic [1:0] quad_phase(input logic [1:0] ab);
        return {ab[1], ab[1] ^ ab[0]};
    endfunction

    function automatic logic signed [POS_W-1:0] step_pos(
        input logic signed [POS_W-1:0] pos, input logic up);
        return up ? pos + POS_ONE : pos - POS_ONE;
    endfunction

    logic [1:0]            cap_q, meta_q, sync_q;
    logic [1:0]            filt_q, filt_d, prev_q, prev_d;
    logic [1:0][FCW-1:0]   fcnt_q, fcnt_d;
    logic [ICW-1:0]        init_q, init_d;
    logic                  primed_q, primed_d;
    logic                  dec_fwd_q, dec_fwd_d, dec_rev_q, dec_rev_d, dec_err_q, dec_err_d;
    logic [DIV_W-1:0]      step_cnt_q, step_cnt_d;
    logic                  step_q, step_d, dir_q, dir_d, err_q, err_d;
    logic signed [POS_W-1:0] pos_q, pos_d;
    logic [1:0]            phase_diff;
    logic                  cnt_valid, qualify;
    logic [DIV_W-1:0]      div_last;

    // Init, glitch filter and decode stage
    always_comb begin
        init_d   = init_q;
        primed_d = primed_q;
        filt_d   = filt_q;
        fcnt_d   = fcnt_q;
        prev_d   = primed_q ? filt_q : sync_q;
        if (!primed_q) begin
            fcnt_d = '0;
            if (init_q == INIT_LAST) begin
                filt_d   = sync_q;
                primed_d = 1'b1;
            end else begin
                init_d = init_q + ICW'(1);
            end
        end else begin
            for (int c = 0; c < 2; c++) begin
                if (sync_q[c] == filt_q[c]) begin
                    fcnt_d[c] = '0;
                end else if (fcnt_q[c] == FILT_LAST) begin
                    filt_d[c] = sync_q[c];
                    fcnt_d[c] = '0;
                end else begin
                    fcnt_d[c] = fcnt_q[c] + FCW'(1);
                end
            end
        end
        phase_diff = quad_phase(filt_q) - quad_phase(prev_q);
        dec_fwd_d  = primed_q && (phase_diff == 2'd1);
        dec_rev_d  = primed_q && (phase_diff == 2'd3);
        dec_err_d  = primed_q && (phase_diff == 2'd2);
    end

    // Position, direction and divider stage
    always_comb begin
        cnt_valid  = dec_fwd_q | dec_rev_q;
        qualify    = i_en && cnt_valid &&
                     (i_dir_mode[1] || (i_dir_mode[0] ? dec_rev_q : dec_fwd_q));
        div_last   = (i_step_div == '0) ? '0 : i_step_div - DIV_W'(1);
        pos_d      = pos_q;
        dir_d      = dir_q;
        err_d      = dec_err_q;
        step_d     = 1'b0;
        step_cnt_d = step_cnt_q;
        if (cnt_valid) begin
            pos_d = step_pos(pos_q, dec_fwd_q);
            dir_d = dec_rev_q;
        end
        if (!i_en) begin
            step_cnt_d = '0;
        end else if (qualify) begin
            // >= so a divider reduced mid-count fires on the next count
            if (step_cnt_q >= div_last) begin
                step_d     = 1'b1;
                step_cnt_d = '0;
            end else begin
                step_cnt_d = step_cnt_q + DIV_W'(1);
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_aresetn) begin
        if (!i_aresetn) begin
            cap_q      <= '0;
            meta_q     <= '0;
            sync_q     <= '0;
            filt_q     <= '0;
            prev_q     <= '0;
            fcnt_q     <= '0;
            init_q     <= '0;
            primed_q   <= 1'b0;
            dec_fwd_q  <= 1'b0;
            dec_rev_q  <= 1'b0;
            dec_err_q  <= 1'b0;
            step_cnt_q <= '0;
            step_q     <= 1'b0;
            pos_q      <= '0;
            dir_q      <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            // Capture flop then two-flop synchroniser: level lags sampling edge by 2
            cap_q      <= {enc_a, enc_b};
            meta_q     <= cap_q;
            sync_q     <= meta_q;
            filt_q     <= filt_d;
            prev_q     <= prev_d;
            fcnt_q     <= fcnt_d;
            init_q     <= init_d;
            primed_q   <= primed_d;
            dec_fwd_q  <= dec_fwd_d;
            dec_rev_q  <= dec_rev_d;
            dec_err_q  <= dec_err_d;
            step_cnt_q <= step_cnt_d;
            step_q     <= step_d;
            pos_q      <= pos_d;
            dir_q      <= dir_d;
            err_q      <= err_d;
        end
    end

    assign o_step     = step_q;
    assign o_position = pos_q;
    assign o_dir      = dir_q;
    assign o_err      = err_q;
endmodule

// File: tb/tb_sv_encoder_step_gen.sv
// Bench for sv_encoder_step_gen: behavioural model compared every cycle, plus
// directed scenarios with hand-computed expectations and a randomized phase.
module tb_sv_encoder_step_gen;
    localparam int FL    = 4;
    localparam int DIV_W = 16;
    localparam int POS_W = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic enc_a = 1'b0, enc_b = 1'b0, en = 1'b0;
    logic [1:0] mode = 2'b10;
    logic [DIV_W-1:0] step_div = 16'd1;
    logic o_step, o_dir, o_err;
    logic signed [POS_W-1:0] o_pos;

    always #5 clk = ~clk;

    sv_encoder_step_gen #(.FILT_LEN(FL), .DIV_W(DIV_W), .POS_W(POS_W)) dut (
        .i_clk(clk), .i_aresetn(rst_n), .enc_a(enc_a), .enc_b(enc_b),
        .i_en(en), .i_dir_mode(mode), .i_step_div(step_div),
        .o_step(o_step), .o_position(o_pos), .o_dir(o_dir), .o_err(o_err)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int step_seen = 0;
    int err_seen  = 0;

    task automatic chk(input string name, input logic signed [63:0] act,
                       input logic signed [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // ---------------- behavioural model ----------------
    int ph [4] = '{0, 1, 3, 2};       // index {A,B}: place along 00->01->11->10
    logic [1:0] rawq [$];
    logic [1:0] synq [$];
    int evq [$];
    logic [1:0] m_filt, prev_f, seen;
    bit   m_primed, run;
    int   m_edges, ev, a, eff, m_cnt;
    logic signed [POS_W-1:0] m_pos;
    logic m_dir, m_step, m_err;

    initial begin
        m_filt = 0; m_primed = 0; m_edges = 0; m_cnt = 0;
        m_pos = 0; m_dir = 0; m_step = 0; m_err = 0;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                rawq.delete(); synq.delete(); evq.delete();
                m_filt = 0; m_primed = 0; m_edges = 0; m_cnt = 0;
                m_pos = 0; m_dir = 0; m_step = 0; m_err = 0;
            end else begin
                m_edges++;
                rawq.push_front({enc_a, enc_b});
                if (rawq.size() > 8) void'(rawq.pop_back());
                seen = (rawq.size() > 3) ? rawq[3] : 2'b00;
                synq.push_front(seen);
                if (synq.size() > 8) void'(synq.pop_back());
                prev_f = m_filt;
                ev = 0;
                if (!m_primed) begin
                    if (m_edges == FL + 2) begin
                        m_filt = seen;
                        m_primed = 1;
                    end
                end else begin
                    // a channel follows once its level has differed for FL edges running
                    for (int c = 0; c < 2; c++) begin
                        run = (synq.size() >= FL);
                        for (int j = 0; j < FL; j++)
                            if (run && synq[j][c] == prev_f[c]) run = 0;
                        if (run) m_filt[c] = synq[0][c];
                    end
                    ev = (ph[m_filt] - ph[prev_f] + 4) % 4;
                end
                a = (evq.size() >= 2) ? evq.pop_front() : 0;
                evq.push_back(ev);
                m_step = 0;
                m_err  = (a == 2);
                if (a == 1 || a == 3) begin
                    m_pos = (a == 1) ? m_pos + 1 : m_pos - 1;
                    m_dir = (a == 3);
                end
                eff = (step_div == 0) ? 1 : int'(step_div);
                if (!en) m_cnt = 0;
                else if ((a == 1 || a == 3) &&
                         (mode[1] || (mode == 2'b00 && a == 1) || (mode == 2'b01 && a == 3))) begin
                    m_cnt++;
                    if (m_cnt >= eff) begin
                        m_step = 1;
                        m_cnt = 0;
                    end
                end
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    initial forever begin
        @(negedge clk);
        chk("step", o_step, m_step);
        chk("err", o_err, m_err);
        chk("position", o_pos, m_pos);
        chk("dir", o_dir, m_dir);
        if (o_step === 1'b1) step_seen++;
        if (o_err === 1'b1) err_seen++;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    logic [1:0] abv [4] = '{2'b00, 2'b01, 2'b11, 2'b10};
    int p = 0;

    task automatic hold_ab(input logic [1:0] ab, input int cycles);
        enc_a = ab[1];
        enc_b = ab[0];
        repeat (cycles) @(negedge clk);
    endtask

    task automatic move(input int dirn, input int cycles);
        p = (p + dirn + 4) % 4;
        hold_ab(abv[p], cycles);
    endtask

    task automatic do_reset(input logic [1:0] ab);
        @(negedge clk);
        #2 rst_n = 1'b0;
        enc_a = ab[1];
        enc_b = ab[0];
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;
        repeat (FL + 8) @(negedge clk);
        step_seen = 0;
        err_seen  = 0;
    endtask

    int samp, lat, exp_steps;

    initial begin
        // Reset held with A=B=1: nothing may happen after release
        do_reset(2'b11);
        en = 1; mode = 2'b10; step_div = 1;
        repeat (30) @(negedge clk);
        chk("idle_steps", step_seen, 0);
        chk("idle_errs", err_seen, 0);
        chk("idle_pos", o_pos, 0);

        // Forward cycle, div 1, both directions; first pulse latency
        do_reset(2'b00);
        p = 0;
        p = 1;
        enc_a = 1'b0; enc_b = 1'b1;
        samp = cyc + 1;
        lat = -1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (o_step === 1'b1) begin
                lat = cyc - samp;
                break;
            end
        end
        chk("first_step_latency", lat, 8);
        repeat (4) @(negedge clk);
        move(1, 10);
        move(1, 10);
        move(1, 12);
        chk("fwd_steps", step_seen, 4);
        chk("fwd_pos", o_pos, 4);
        chk("fwd_dir", o_dir, 0);

        // Glitch rejection
        do_reset(2'b00);
        hold_ab(2'b10, 3);
        hold_ab(2'b00, 14);
        chk("glitch_pos", o_pos, 0);
        chk("glitch_steps", step_seen, 0);
        hold_ab(2'b01, 14);
        chk("long_pulse_pos", o_pos, 1);
        chk("long_pulse_steps", step_seen, 1);

        // Divider 3, forward-only mode
        do_reset(2'b00);
        p = 0; mode = 2'b00; step_div = 3;
        for (int i = 1; i <= 7; i++) begin
            move(1, 10);
            exp_steps = i / 3;
            chk("div3_steps", step_seen, exp_steps);
        end
        move(-1, 10);
        move(-1, 10);
        chk("div3_steps_after_rev", step_seen, 2);
        chk("div3_pos", o_pos, 5);
        chk("div3_dir", o_dir, 1);
        step_div = 1;
        move(1, 10);
        chk("div_reduced_steps", step_seen, 3);
        chk("div_reduced_pos", o_pos, 6);

        // Illegal jump 00 -> 11
        do_reset(2'b00);
        mode = 2'b10; step_div = 1;
        hold_ab(2'b11, 15);
        chk("illegal_err_cycles", err_seen, 1);
        chk("illegal_pos", o_pos, 0);
        chk("illegal_steps", step_seen, 0);

        // Enable gating, div 2, then reset mid-sequence
        do_reset(2'b00);
        p = 0; mode = 2'b10; step_div = 2; en = 0;
        repeat (3) move(1, 10);
        chk("disabled_pos", o_pos, 3);
        chk("disabled_steps", step_seen, 0);
        en = 1;
        move(1, 10);
        chk("reenable_first_steps", step_seen, 0);
        move(1, 10);
        chk("reenable_second_steps", step_seen, 1);
        chk("reenable_pos", o_pos, 5);
        move(1, 6);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_step", o_step, 0);
        chk("async_rst_pos", o_pos, 0);
        chk("async_rst_dir", o_dir, 0);
        chk("async_rst_err", o_err, 0);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        step_seen = 0;
        move(1, FL + 2);
        chk("post_rst_pos", o_pos, 0);
        chk("post_rst_steps", step_seen, 0);

        // Randomized phase against the model
        do_reset(2'b00);
        p = 0;
        for (int s = 0; s < 300; s++) begin
            if ($urandom_range(0, 9) == 0) en = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 9) == 0) mode = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 9) == 0) step_div = DIV_W'($urandom_range(0, 4));
            if (s == 150) begin
                @(negedge clk);
                #3 rst_n = 1'b0;
                @(negedge clk);
                #2 rst_n = 1'b1;
            end
            case ($urandom_range(0, 9))
                0:       move(2, $urandom_range(1, 12));
                1, 2:    hold_ab(abv[p], $urandom_range(1, 12));
                3, 4, 5: move(1, $urandom_range(1, 12));
                default: move(-1, $urandom_range(1, 12));
            endcase
        end
        repeat (20) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
